// File: rtl/start_guard_if.sv
// Bus interface for the start_guard register: one strobe, zero-wait-state
// read/write access. Valid/ready: a transfer happens in every cycle where
// stb is high; ack mirrors stb combinationally, so the slave is always ready.
interface start_guard_if;
  logic        stb;
  logic        we;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;

  modport master (
    output stb,
    output we,
    output data_in,
    input  data_out,
    input  ack
  );

  modport slave (
    input  stb,
    input  we,
    input  data_in,
    output data_out,
    output ack
  );
endinterface

// File: rtl/start_guard.sv
// start_guard: holds the selected start-table number and an armed flag across
// system restarts. Counts consecutive unconfirmed restarts and, after
// MAX_TRIES of them, forces FALLBACK_TABLE and disarms until software confirms.
// Reset does not clear the held state; it only triggers one update per
// assertion. Power-on values come from the declaration initialisers
// (configuration load), not from rst.
module start_guard #(
  parameter int                 TABLE_W        = 8,
  parameter int                 CNT_W          = 4,
  parameter int                 MAX_TRIES      = 3,
  parameter logic [TABLE_W-1:0] FALLBACK_TABLE = '0,
  parameter logic [TABLE_W-1:0] INIT_TABLE     = '0
) (
  input  logic               clk,
  input  logic               rst,
  start_guard_if.slave       bus,
  output logic [TABLE_W-1:0] table_out,
  output logic               armed_out,
  output logic               fallback_out
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TRIES);
  localparam logic [CNT_W:0]   MAX_EXT = (CNT_W+1)'(MAX_TRIES);
  localparam logic [CNT_W:0]   ONE_EXT = (CNT_W+1)'(1);

  // Held state; initialisers give the configuration (power-on) values.
  logic [TABLE_W-1:0] table_q    = INIT_TABLE;
  logic               armed_q    = 1'b0;
  logic [CNT_W-1:0]   cnt_q      = '0;
  logic               fallback_q = 1'b0;
  logic               rst_q      = 1'b1;

  logic [7:0]         ctrl;
  logic [TABLE_W-1:0] wr_table;
  logic               reset_entry;
  logic               wr_en;
  logic [CNT_W:0]     cnt_inc;
  logic               unused_bits;

  assign ctrl        = bus.data_in[7:0];
  assign wr_table    = bus.data_in[TABLE_W+7:8];
  assign reset_entry = ~rst & rst_q;
  assign wr_en       = bus.stb & bus.we & rst;
  // One extra bit so cnt+1 cannot wrap before the compare.
  assign cnt_inc     = {1'b0, cnt_q} + ONE_EXT;
  assign unused_bits = ^{bus.data_in[31:TABLE_W+8], ctrl[7:4]};

  // Reset-entry update (once per rst falling edge) and bus register writes.
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (reset_entry) begin
      if (MAX_TRIES == 0) begin
        armed_q <= 1'b1;
      end else if (fallback_q) begin
        armed_q <= 1'b0;
      end else if (cnt_inc >= MAX_EXT) begin
        table_q    <= FALLBACK_TABLE;
        fallback_q <= 1'b1;
        armed_q    <= 1'b0;
        cnt_q      <= MAX_CNT;
      end else begin
        cnt_q   <= cnt_inc[CNT_W-1:0];
        armed_q <= 1'b1;
      end
    end else if (wr_en) begin
      if (ctrl[0]) begin
        table_q <= wr_table;
      end
      // Disarm takes priority over arm when both bits are set.
      if (ctrl[2]) begin
        armed_q <= 1'b0;
      end else if (ctrl[1]) begin
        armed_q <= 1'b1;
      end
      if (ctrl[3]) begin
        cnt_q      <= '0;
        fallback_q <= 1'b0;
      end
    end
  end

  // Combinational read mux and acknowledge; data_out is zero unless reading.
  always_comb begin
    bus.data_out = '0;
    bus.ack      = bus.stb;
    if (bus.stb && !bus.we) begin
      bus.data_out[TABLE_W-1:0] = table_q;
      bus.data_out[16]          = armed_q;
      bus.data_out[17]          = fallback_q;
      bus.data_out[24 +: CNT_W] = cnt_q;
    end
  end

  assign table_out    = table_q;
  assign armed_out    = armed_q;
  assign fallback_out = fallback_q;

endmodule

// File: tb/tb_start_guard.sv
// Bench for start_guard: a table of per-cycle vectors drives the main build
// (MAX_TRIES=3, FALLBACK_TABLE=FF), then hand-written sequences exercise a
// build with the fallback disabled (MAX_TRIES=0, INIT_TABLE=3C).
module tb_start_guard;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  start_guard_if bus_a ();
  start_guard_if bus_b ();

  logic [7:0] table_a, table_b;
  logic       armed_a, armed_b, fb_a, fb_b;

  start_guard #(
    .TABLE_W(8), .CNT_W(4), .MAX_TRIES(3),
    .FALLBACK_TABLE(8'hFF), .INIT_TABLE(8'h00)
  ) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a.slave),
    .table_out(table_a), .armed_out(armed_a), .fallback_out(fb_a)
  );

  start_guard #(
    .TABLE_W(8), .CNT_W(4), .MAX_TRIES(0),
    .FALLBACK_TABLE(8'hAA), .INIT_TABLE(8'h3C)
  ) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b.slave),
    .table_out(table_b), .armed_out(armed_b), .fallback_out(fb_b)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        stb;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        ack;
    logic [7:0]  tbl;
    logic        arm;
    logic        fb;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic s, input logic w, input logic [31:0] d,
                     input logic [31:0] o, input logic a, input logic [7:0] t,
                     input logic m, input logic f);
    vec_t v;
    v = '{r, s, w, d, o, a, t, m, f};
    vq.push_back(v);
  endtask

  // ---------------- driver tasks for build B ----------------
  task automatic b_read(input string name, input logic [31:0] exp);
    exp_q.push_back(exp);
    @(posedge clk); #1;
    bus_b.stb = 1'b1; bus_b.we = 1'b0; bus_b.data_in = '0;
    @(negedge clk);
    check(name, bus_b.data_out, exp_q.pop_front());
    check({name, "_ack"}, {31'd0, bus_b.ack}, 32'd1);
    @(posedge clk); #1;
    bus_b.stb = 1'b0;
  endtask

  task automatic b_write(input logic [31:0] d);
    @(posedge clk); #1;
    bus_b.stb = 1'b1; bus_b.we = 1'b1; bus_b.data_in = d;
    @(posedge clk); #1;
    bus_b.stb = 1'b0; bus_b.we = 1'b0;
  endtask

  task automatic b_reset(input int cycles);
    @(posedge clk); #1;
    rst_b = 1'b0;
    repeat (cycles - 1) @(posedge clk);
    @(posedge clk); #1;
    rst_b = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus_a.stb = 1'b0; bus_a.we = 1'b0; bus_a.data_in = '0;
    bus_b.stb = 1'b0; bus_b.we = 1'b0; bus_b.data_in = '0;

    // Each row: inputs for the cycle, then outputs expected mid-cycle
    // (read data/ack from the inputs, status from state before the edge).
    //   rst stb we  din            dout           ack tbl    arm  fb
    add(1, 1, 0, 32'h0,          32'h0000_0000, 1, 8'h00, 0, 0); // power-on read
    add(1, 0, 0, 32'h0,          32'h0000_0000, 0, 8'h00, 0, 0); // idle: data_out 0
    add(1, 1, 1, 32'h0000_0501,  32'h0000_0000, 1, 8'h00, 0, 0); // set table 05
    add(1, 1, 0, 32'h0,          32'h0000_0005, 1, 8'h05, 0, 0);
    add(0, 0, 0, 32'h0,          32'h0000_0000, 0, 8'h05, 0, 0); // pulse 1 (1 cycle)
    add(1, 1, 0, 32'h0,          32'h0101_0005, 1, 8'h05, 1, 0); // cnt=1 armed
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 32'h0,        32'h0000_0000, 0, 8'h05, 1, 0); // pulse 2 (5 cycles)
    add(1, 1, 0, 32'h0,          32'h0201_0005, 1, 8'h05, 1, 0); // cnt=2
    add(0, 0, 0, 32'h0,          32'h0000_0000, 0, 8'h05, 1, 0); // pulse 3 (2 cycles)
    add(0, 0, 0, 32'h0,          32'h0000_0000, 0, 8'hFF, 0, 1);
    add(1, 1, 0, 32'h0,          32'h0302_00FF, 1, 8'hFF, 0, 1); // fallback
    add(0, 0, 0, 32'h0,          32'h0000_0000, 0, 8'hFF, 0, 1); // 4th reset
    add(1, 1, 0, 32'h0,          32'h0302_00FF, 1, 8'hFF, 0, 1); // unchanged
    add(1, 1, 1, 32'h0000_0008,  32'h0000_0000, 1, 8'hFF, 0, 1); // confirm
    add(1, 1, 0, 32'h0,          32'h0000_00FF, 1, 8'hFF, 0, 0);
    add(0, 0, 0, 32'h0,          32'h0000_0000, 0, 8'hFF, 0, 0); // reset after confirm
    add(1, 1, 0, 32'h0,          32'h0101_00FF, 1, 8'hFF, 1, 0); // cnt=1 armed
    // Reset held 10 cycles with a write and a read during it.
    add(0, 0, 0, 32'h0,          32'h0000_0000, 0, 8'hFF, 1, 0);
    add(0, 0, 0, 32'h0,          32'h0000_0000, 0, 8'hFF, 1, 0);
    add(0, 0, 0, 32'h0,          32'h0000_0000, 0, 8'hFF, 1, 0);
    add(0, 0, 0, 32'h0,          32'h0000_0000, 0, 8'hFF, 1, 0);
    add(0, 1, 1, 32'h0000_3305,  32'h0000_0000, 1, 8'hFF, 1, 0); // ignored write
    add(0, 0, 0, 32'h0,          32'h0000_0000, 0, 8'hFF, 1, 0);
    add(0, 1, 0, 32'h0,          32'h0201_00FF, 1, 8'hFF, 1, 0); // read in reset
    add(0, 0, 0, 32'h0,          32'h0000_0000, 0, 8'hFF, 1, 0);
    add(0, 0, 0, 32'h0,          32'h0000_0000, 0, 8'hFF, 1, 0);
    add(0, 0, 0, 32'h0,          32'h0000_0000, 0, 8'hFF, 1, 0);
    add(1, 1, 0, 32'h0,          32'h0201_00FF, 1, 8'hFF, 1, 0); // counted once
    add(1, 1, 1, 32'h0000_220F,  32'h0000_0000, 1, 8'hFF, 1, 0); // all ctrl bits
    add(1, 1, 0, 32'h0,          32'h0000_0022, 1, 8'h22, 0, 0); // disarm wins
    // Back into fallback, then set table while in fallback.
    add(0, 0, 0, 32'h0,          32'h0000_0000, 0, 8'h22, 0, 0);
    add(1, 0, 0, 32'h0,          32'h0000_0000, 0, 8'h22, 1, 0);
    add(0, 0, 0, 32'h0,          32'h0000_0000, 0, 8'h22, 1, 0);
    add(1, 0, 0, 32'h0,          32'h0000_0000, 0, 8'h22, 1, 0);
    add(0, 0, 0, 32'h0,          32'h0000_0000, 0, 8'h22, 1, 0);
    add(1, 1, 0, 32'h0,          32'h0302_00FF, 1, 8'hFF, 0, 1);
    add(1, 1, 1, 32'h0000_4401,  32'h0000_0000, 1, 8'hFF, 0, 1); // set table in fallback
    add(1, 1, 0, 32'h0,          32'h0302_0044, 1, 8'h44, 0, 1); // fallback stays
    add(1, 1, 1, 32'h0000_000A,  32'h0000_0000, 1, 8'h44, 0, 1); // arm + confirm
    add(1, 1, 0, 32'h0,          32'h0001_0044, 1, 8'h44, 1, 0);

    foreach (vq[i]) begin
      @(posedge clk); #1;
      rst_a = vq[i].rst;
      bus_a.stb = vq[i].stb;
      bus_a.we = vq[i].we;
      bus_a.data_in = vq[i].din;
      @(negedge clk);
      check($sformatf("a_dout[%0d]", i), bus_a.data_out, vq[i].dout);
      check($sformatf("a_ack[%0d]", i), {31'd0, bus_a.ack}, {31'd0, vq[i].ack});
      check($sformatf("a_table[%0d]", i), {24'd0, table_a}, {24'd0, vq[i].tbl});
      check($sformatf("a_armed[%0d]", i), {31'd0, armed_a}, {31'd0, vq[i].arm});
      check($sformatf("a_fb[%0d]", i), {31'd0, fb_a}, {31'd0, vq[i].fb});
    end
    @(posedge clk); #1;
    bus_a.stb = 1'b0; bus_a.we = 1'b0; rst_a = 1'b1;

    // Build B: fallback disabled, every reset re-arms, counter never moves.
    b_read("b_poweron", 32'h0000_003C);
    check("b_poweron_armed", {31'd0, armed_b}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      b_write(32'h0000_0004);
      @(negedge clk);
      check($sformatf("b_disarmed[%0d]", k), {31'd0, armed_b}, 32'd0);
      b_reset(k + 1);
      b_read($sformatf("b_after_reset[%0d]", k), 32'h0001_003C);
      check($sformatf("b_armed[%0d]", k), {31'd0, armed_b}, 32'd1);
      check($sformatf("b_fb[%0d]", k), {31'd0, fb_b}, 32'd0);
      check($sformatf("b_table[%0d]", k), {24'd0, table_b}, 32'h0000_003C);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
